// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between instruction fetch (I) and data (D).
// D wins by default; after MAX_WAIT back-to-back D grants with I waiting, I is forced through.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 256
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_we,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state, stateNxt;
  logic [WW-1:0] waitCnt, waitNxt;
  logic [TW-1:0] tmoCnt, tmoNxt;
  logic          memReqNxt, memWeNxt;
  logic [AW-1:0] memAddrNxt;
  logic [DW-1:0] memWdataNxt;
  logic          tmoHit, finish;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state     <= IDLE;
      waitCnt   <= '0;
      tmoCnt    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= stateNxt;
      waitCnt   <= waitNxt;
      tmoCnt    <= tmoNxt;
      mem_req   <= memReqNxt;
      mem_we    <= memWeNxt;
      mem_addr  <= memAddrNxt;
      mem_wdata <= memWdataNxt;
    end
  end

  // A hung memory is cut off on its last allowed cycle; a real mem_ready there still wins.
  assign tmoHit = (TIMEOUT > 0) && (state != IDLE) && !mem_ready && (tmoCnt == TMO_LAST);
  assign finish = mem_ready || tmoHit;

  always_comb begin
    stateNxt    = state;
    waitNxt     = waitCnt;
    tmoNxt      = tmoCnt;
    memReqNxt   = mem_req;
    memWeNxt    = mem_we;
    memAddrNxt  = mem_addr;
    memWdataNxt = mem_wdata;
    case (state)
      IDLE: begin
        if (d_req && !(i_req && waitCnt == WAIT_MAX)) begin
          stateNxt    = BUSY_D;
          memReqNxt   = 1'b1;
          memAddrNxt  = d_addr;
          memWdataNxt = d_wdata;
          memWeNxt    = d_we;
          tmoNxt      = '0;
          if (!i_req)                waitNxt = '0;
          else if (waitCnt != WAIT_MAX) waitNxt = waitCnt + 1'b1;
        end else if (i_req) begin
          stateNxt   = BUSY_I;
          memReqNxt  = 1'b1;
          memAddrNxt = i_addr;
          memWeNxt   = 1'b0;
          tmoNxt     = '0;
          waitNxt    = '0;
        end else begin
          waitNxt = '0;
        end
      end
      default: begin
        if (finish) begin
          stateNxt  = IDLE;
          memReqNxt = 1'b0;
          memWeNxt  = 1'b0;
        end else begin
          tmoNxt = tmoCnt + 1'b1;
        end
      end
    endcase
  end

  assign i_done  = (state == BUSY_I) && finish;
  assign i_err   = (state == BUSY_I) && tmoHit;
  assign i_rdata = ((state == BUSY_I) && !tmoHit) ? mem_rdata : '0;
  assign d_done  = (state == BUSY_D) && finish;
  assign d_err   = (state == BUSY_D) && tmoHit;
  assign d_rdata = ((state == BUSY_D) && !tmoHit) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table for single accesses, hand sequences
// for starvation guard, timeout and mid-access reset.
module tb_mem_port_arbiter;
  logic        clk = 1'b0, n_reset = 1'b0;
  logic        i_req = 0, d_req = 0, d_we = 0, mem_ready = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic        i_done, i_err, d_done, d_err, mem_req, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  int nCmp = 0, nErr = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4), .TIMEOUT(8)) dut (
    .clk(clk), .n_reset(n_reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic iReq; logic [31:0] iAddr;
    logic dReq; logic [31:0] dAddr; logic [31:0] dWdata; logic dWe;
    logic memReady; logic [31:0] memRdata;
    logic eIDone; logic [31:0] eIRdata; logic eDDone; logic [31:0] eDRdata;
    logic eMemReq; logic [31:0] eMemAddr; logic eMemWe; logic [31:0] eMemWdata;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string seq, expSeq;
    int    cyc;
    vecs[0]  = '{0, 32'h0,  0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,   0, 32'h0};
    vecs[1]  = '{1, 32'h10, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,   0, 32'h0};
    vecs[2]  = '{1, 32'h10, 0, 32'h0,   32'h0,        0, 1, 32'h00500093, 1, 32'h00500093, 0, 32'h0,        1, 32'h10,  0, 32'h0};
    vecs[3]  = '{0, 32'h0,  0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,   0, 32'h0};
    vecs[4]  = '{1, 32'h14, 1, 32'h100, 32'hDEADBEEF, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,   0, 32'h0};
    vecs[5]  = '{1, 32'h14, 1, 32'h100, 32'hDEADBEEF, 1, 1, 32'h0BADF00D, 0, 32'h0,        1, 32'h0BADF00D, 1, 32'h100, 1, 32'hDEADBEEF};
    vecs[6]  = '{1, 32'h14, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,   0, 32'h0};
    vecs[7]  = '{1, 32'h14, 0, 32'h0,   32'h0,        0, 1, 32'h00001234, 1, 32'h00001234, 0, 32'h0,        1, 32'h14,  0, 32'h0};
    vecs[8]  = '{0, 32'h0,  0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,   0, 32'h0};
    vecs[9]  = '{0, 32'h0,  1, 32'h200, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,   0, 32'h0};
    vecs[10] = '{0, 32'h0,  1, 32'h200, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h200, 0, 32'h0};
    vecs[11] = '{0, 32'h0,  1, 32'h200, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h200, 0, 32'h0};
    // Requester drops d_req and changes d_addr mid-access: access must still finish on 0x200.
    vecs[12] = '{0, 32'h0,  0, 32'h0,   32'h0,        0, 1, 32'hCAFE0001, 0, 32'h0,        1, 32'hCAFE0001, 1, 32'h200, 0, 32'h0};
    vecs[13] = '{0, 32'h0,  0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,   0, 32'h0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    n_reset = 1'b1;

    for (int r = 0; r < 14; r++) begin
      if (r != 0) @(negedge clk);
      i_req = vecs[r].iReq; i_addr = vecs[r].iAddr;
      d_req = vecs[r].dReq; d_addr = vecs[r].dAddr; d_wdata = vecs[r].dWdata; d_we = vecs[r].dWe;
      mem_ready = vecs[r].memReady; mem_rdata = vecs[r].memRdata;
      #4;
      chk($sformatf("row%0d_i_done", r), i_done, vecs[r].eIDone);
      chk($sformatf("row%0d_i_rdata", r), i_rdata, vecs[r].eIRdata);
      chk($sformatf("row%0d_i_err", r), i_err, 0);
      chk($sformatf("row%0d_d_done", r), d_done, vecs[r].eDDone);
      chk($sformatf("row%0d_d_rdata", r), d_rdata, vecs[r].eDRdata);
      chk($sformatf("row%0d_d_err", r), d_err, 0);
      chk($sformatf("row%0d_mem_req", r), mem_req, vecs[r].eMemReq);
      chk($sformatf("row%0d_mem_we", r), mem_we, vecs[r].eMemWe);
      if (vecs[r].eMemReq) chk($sformatf("row%0d_mem_addr", r), mem_addr, vecs[r].eMemAddr);
      if (vecs[r].eMemWe) chk($sformatf("row%0d_mem_wdata", r), mem_wdata, vecs[r].eMemWdata);
    end

    // Starvation guard: both requesting, 1-cycle memory, mem_ready also high in IDLE.
    @(negedge clk);
    i_req = 1; i_addr = 32'h80; d_req = 1; d_addr = 32'h400; d_we = 0;
    mem_ready = 1; mem_rdata = 32'h0;
    seq = ""; expSeq = "DDDDIDDDDI"; cyc = 0;
    while (seq.len() < 10 && cyc < 40) begin
      if (cyc != 0) @(negedge clk);
      #4;
      if (i_done && d_done) chk("both_done", 1, 0);
      if (d_done) seq = {seq, "D"};
      if (i_done) seq = {seq, "I"};
      cyc++;
    end
    chk("starve_count", seq.len(), 10);
    for (int k = 0; k < seq.len() && k < 10; k++)
      chk($sformatf("starve_grant%0d", k), seq[k], expSeq[k]);

    // Timeout: memory never answers.
    @(negedge clk);
    i_req = 0; d_req = 1; d_addr = 32'h300; d_we = 0; mem_ready = 0; mem_rdata = 32'hFFFFFFFF;
    #4;
    chk("tmo_idle_done", d_done, 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #4;
      chk($sformatf("tmo_b%0d_mem_req", k), mem_req, 1);
      chk($sformatf("tmo_b%0d_done", k), d_done, (k == 8));
      chk($sformatf("tmo_b%0d_err", k), d_err, (k == 8));
      if (k == 8) chk("tmo_rdata", d_rdata, 0);
    end
    @(negedge clk);
    d_req = 0;
    #4;
    chk("tmo_after_mem_req", mem_req, 0);
    chk("tmo_after_done", d_done, 0);

    // mem_ready arriving on the last allowed cycle is a normal completion.
    @(negedge clk);
    d_req = 1; d_addr = 32'h304; d_wdata = 32'h55; d_we = 1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 8) begin mem_ready = 1; mem_rdata = 32'h77; end
      #4;
      chk($sformatf("late_b%0d_done", k), d_done, (k == 8));
      chk($sformatf("late_b%0d_err", k), d_err, 0);
    end
    chk("late_rdata", d_rdata, 32'h77);
    chk("late_mem_wdata", mem_wdata, 32'h55);
    chk("late_mem_we", mem_we, 1);
    @(negedge clk);
    d_req = 0; mem_ready = 0; d_we = 0;
    #4;
    chk("late_after_mem_req", mem_req, 0);

    // Reset in the second BUSY_I cycle abandons the fetch.
    @(negedge clk);
    i_req = 1; i_addr = 32'h40;
    @(negedge clk); #4;
    chk("rst_busy1_mem_req", mem_req, 1);
    @(negedge clk);
    n_reset = 0;
    @(negedge clk);
    n_reset = 1; i_req = 0; mem_ready = 1; mem_rdata = 32'h99;
    #4;
    chk("rst_after_mem_req", mem_req, 0);
    chk("rst_after_i_done", i_done, 0);
    chk("rst_after_d_done", d_done, 0);
    @(negedge clk);
    i_req = 1; i_addr = 32'h20; mem_ready = 0; mem_rdata = 0;
    #4;
    chk("rst_new_idle_mem_req", mem_req, 0);
    @(negedge clk);
    mem_ready = 1; mem_rdata = 32'h00500093;
    #4;
    chk("rst_new_mem_req", mem_req, 1);
    chk("rst_new_mem_addr", mem_addr, 32'h20);
    chk("rst_new_mem_we", mem_we, 0);
    chk("rst_new_i_done", i_done, 1);
    chk("rst_new_i_rdata", i_rdata, 32'h00500093);
    @(negedge clk);
    i_req = 0; mem_ready = 0;
    #4;
    chk("rst_new_after_mem_req", mem_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
